// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a transmit-only UART through a held write strobe.
// Each byte is paced on the UART's ready pulse, with a timeout that recovers from a lost pulse.
module uart_tx_queue #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned TIMEOUT_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic                  uart_wstrb,
  output logic [7:0]            uart_dat,
  input  logic                  uart_ready
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned SCNT_W = $clog2(STROBE_CYCLES + 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT
  } state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_e                state_q, state_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
  logic [7:0]            dat_q, dat_d;
  logic                  ovf_q, ovf_d;
  logic                  to_q, to_d;
  logic                  pop, push;

  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_FULL);
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign timeout_err = to_q;
  assign uart_wstrb  = (state_q == S_STROBE);
  assign uart_dat    = dat_q;

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    dat_d   = dat_q;
    to_d    = to_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          dat_d   = mem_q[rptr_q];
          scnt_d  = SCNT_W'(STROBE_CYCLES);
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        scnt_d = scnt_q - 1'b1;
        if (scnt_q == SCNT_W'(1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (uart_ready) begin
          tcnt_d  = '0;
          state_d = S_IDLE;
        end else if (&tcnt_q) begin
          // A lost ready pulse is treated as a completed byte
          tcnt_d  = '0;
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    push    = wr_en && (!full || pop);
    ovf_d   = ovf_q || (wr_en && full && !pop);
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= wr_data;
  end

endmodule
